fp16_mac_accumulator: RTL and testbench

- Downstream consumer of the FP16 multiplier stage. Sums groups of ACC_LEN FP16 products into one FP16 result with a valid/ready handshake.
- Built as a multi-cycle FSM around a single FP16 adder datapath: align, add, normalize/round.
- Feeds the matmul output writeback in the 4x4 FP16 mode.

---
 rtl/fp16_mac_accumulator.sv | 255 +++++++++++++++++++++++++
 tb/tb_fp16_mac_accumulator.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fp16_mac_accumulator.sv
// Accumulates groups of ACC_LEN FP16 products through one shared align/add/normalize datapath.
// Optional macro FP16ACC_BIAS_INIT_EN adds acc_init, which preloads the accumulator on each group's first product.
module fp16_mac_accumulator #(
  parameter int ACC_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [4:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [4:0]  out_flags,
  output logic        busy
`ifdef FP16ACC_BIAS_INIT_EN
  ,
  input  logic [15:0] acc_init
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

  localparam logic [CNT_W-1:0] ACC_LEN_C = CNT_W'(ACC_LEN);

  state_t            state_q, state_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        flags_q, flags_d;
  logic              sign_q, sign_d;
  logic [4:0]        exp_q, exp_d;
  logic [13:0]       ma_q, ma_d;
  logic [13:0]       mb_q, mb_d;
  logic              sub_q, sub_d;
  logic              spec_q, spec_d;
  logic [15:0]       spec_val_q, spec_val_d;
  logic              spec_inv_q, spec_inv_d;
  logic [14:0]       sum_q, sum_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_data_q, out_data_d;
  logic [4:0]        out_flags_q, out_flags_d;

  logic              unused_flags;
  assign unused_flags = ^in_flags[3:0];

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    lzc14 = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) lzc14 = 4'(13 - i);
    end
  endfunction

  // Alignment: operands flushed, ordered by magnitude, B shifted with sticky collapse
  logic [14:0] x_mag, y_mag, a_mag, b_mag;
  logic        a_sign, b_sign, swap;
  logic [13:0] a_m14, b_m14, b_al, sh_mask;
  logic [4:0]  diff;
  logic        x_nan, y_nan, x_inf, y_inf;

  always_comb begin
    x_mag   = (acc_q[14:10] == 5'd0) ? 15'd0 : acc_q[14:0];
    y_mag   = (prod_q[14:10] == 5'd0) ? 15'd0 : prod_q[14:0];
    swap    = y_mag > x_mag;
    a_mag   = swap ? y_mag : x_mag;
    b_mag   = swap ? x_mag : y_mag;
    a_sign  = swap ? prod_q[15] : acc_q[15];
    b_sign  = swap ? acc_q[15] : prod_q[15];
    a_m14   = (a_mag[14:10] == 5'd0) ? 14'd0 : {1'b1, a_mag[9:0], 3'b000};
    b_m14   = (b_mag[14:10] == 5'd0) ? 14'd0 : {1'b1, b_mag[9:0], 3'b000};
    diff    = a_mag[14:10] - b_mag[14:10];
    sh_mask = (14'd1 << diff) - 14'd1;
    if (diff >= 5'd14) b_al = {13'd0, |b_m14};
    else               b_al = (b_m14 >> diff) | {13'd0, |(b_m14 & sh_mask)};
    x_nan = (&acc_q[14:10]) & (|acc_q[9:0]);
    y_nan = (&prod_q[14:10]) & (|prod_q[9:0]);
    x_inf = (&acc_q[14:10]) & ~(|acc_q[9:0]);
    y_inf = (&prod_q[14:10]) & ~(|prod_q[9:0]);
  end

  // Normalization and round-to-nearest-even of the registered sum
  logic [13:0]        nm;
  logic [3:0]         lz;
  logic signed [6:0]  ne, ne_r;
  logic [11:0]        rm;
  logic               round_up, inexact;
  logic [9:0]         man_r;
  logic [15:0]        res;
  logic [4:0]         res_fl;

  always_comb begin
    lz = lzc14(sum_q[13:0]);
    if (sum_q[14]) begin
      nm = {sum_q[14:2], sum_q[1] | sum_q[0]};
      ne = $signed({2'b00, exp_q}) + 7'sd1;
    end else begin
      nm = sum_q[13:0] << lz;
      ne = $signed({2'b00, exp_q}) - $signed({3'b000, lz});
    end
    round_up = nm[2] & (nm[1] | nm[0] | nm[3]);
    inexact  = |nm[2:0];
    rm       = {1'b0, nm[13:3]} + {11'd0, round_up};
    if (rm[11]) begin
      man_r = 10'd0;
      ne_r  = ne + 7'sd1;
    end else begin
      man_r = rm[9:0];
      ne_r  = ne;
    end
    if (spec_q) begin
      res    = spec_val_q;
      res_fl = {spec_inv_q, 4'b0000};
    end else if (sum_q == 15'd0) begin
      res    = 16'h0000;
      res_fl = 5'b00000;
    end else if (ne_r >= 7'sd31) begin
      res    = {sign_q, 5'h1F, 10'd0};
      res_fl = 5'b01010;
    end else if (ne_r <= 7'sd0) begin
      res    = {sign_q, 15'd0};
      res_fl = 5'b00110;
    end else begin
      res    = {sign_q, ne_r[4:0], man_r};
      res_fl = {3'b000, inexact, 1'b0};
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    sub_d       = sub_q;
    spec_d      = spec_q;
    spec_val_d  = spec_val_q;
    spec_inv_d  = spec_inv_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          prod_d     = in_data;
          flags_d[0] = flags_q[0] | in_flags[4];
`ifdef FP16ACC_BIAS_INIT_EN
          if (cnt_q == '0) acc_d = acc_init;
`endif
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sign_d     = a_sign;
        exp_d      = a_mag[14:10];
        ma_d       = a_m14;
        mb_d       = b_al;
        sub_d      = a_sign ^ b_sign;
        spec_d     = x_nan | y_nan | x_inf | y_inf;
        spec_inv_d = 1'b0;
        if (x_nan || y_nan) begin
          spec_val_d = 16'h7E00;
        end else if (x_inf && y_inf && (acc_q[15] != prod_q[15])) begin
          spec_val_d = 16'h7E00;
          spec_inv_d = 1'b1;
        end else if (x_inf) begin
          spec_val_d = acc_q;
        end else begin
          spec_val_d = prod_q;
        end
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d   = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        acc_d   = res;
        flags_d = flags_q | res_fl;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == ACC_LEN_C) ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        // First OUT cycle captures the result; the handshake is only honoured once it is visible
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_q;
          out_flags_d = flags_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = 16'h0000;
          out_flags_d = 5'b00000;
          acc_d       = 16'h0000;
          cnt_d       = '0;
          flags_d     = 5'b00000;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= 16'h0000;
      prod_q      <= 16'h0000;
      cnt_q       <= '0;
      flags_q     <= 5'b00000;
      sign_q      <= 1'b0;
      exp_q       <= 5'd0;
      ma_q        <= 14'd0;
      mb_q        <= 14'd0;
      sub_q       <= 1'b0;
      spec_q      <= 1'b0;
      spec_val_q  <= 16'h0000;
      spec_inv_q  <= 1'b0;
      sum_q       <= 15'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_flags_q <= 5'b00000;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      sub_q       <= sub_d;
      spec_q      <= spec_d;
      spec_val_q  <= spec_val_d;
      spec_inv_q  <= spec_inv_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp16_mac_accumulator.sv
// Directed-vector bench for fp16_mac_accumulator with ACC_LEN=4 and hand-computed FP16 sums.
module tb_fp16_mac_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_flags;
  logic        busy;
`ifdef FP16ACC_BIAS_INIT_EN
  logic [15:0] acc_init;
`endif

  int errors = 0;
  int checks = 0;

  fp16_mac_accumulator #(.ACC_LEN(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .busy      (busy)
`ifdef FP16ACC_BIAS_INIT_EN
    ,
    .acc_init  (acc_init)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic send_product(input logic [15:0] d, input logic exc);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check_eq("ready timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_flags = {exc, 4'b0000};
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    in_flags = 5'b00000;
  endtask

  task automatic run_group(input string name,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3,
                           input logic [3:0] exc,
                           input logic [15:0] exp_data, input logic [4:0] exp_flags,
                           input int hold);
    logic [15:0] v [4];
    int lat;
    v = '{d0, d1, d2, d3};
    out_ready = (hold == 0);
    for (int i = 0; i < 4; i++) begin
      send_product(v[i], exc[i]);
      if (i == 0) check_eq({name, " in_ready low while busy"}, 32'(in_ready), 32'd0);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({name, " latency"}, 32'(lat), 32'd4);
    check_eq({name, " out_data"}, 32'(out_data), 32'(exp_data));
    check_eq({name, " out_flags"}, 32'(out_flags), 32'(exp_flags));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_eq({name, " hold valid"}, 32'(out_valid), 32'd1);
      check_eq({name, " hold data"}, 32'(out_data), 32'(exp_data));
      check_eq({name, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({name, " valid drop"}, 32'(out_valid), 32'd0);
    check_eq({name, " data cleared"}, 32'(out_data), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_flags  = 5'b00000;
    out_ready = 1'b1;
`ifdef FP16ACC_BIAS_INIT_EN
    acc_init  = 16'h0000;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset in_ready", 32'(in_ready), 32'd1);
    check_eq("reset out_valid", 32'(out_valid), 32'd0);
    check_eq("reset out_data", 32'(out_data), 32'd0);
    check_eq("reset out_flags", 32'(out_flags), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_group("ones",        16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 16'h4400, 5'b00000, 0);
    run_group("cancel",      16'h3C00, 16'hBC00, 16'h4000, 16'hC000, 4'b0000, 16'h0000, 5'b00000, 0);
    run_group("tie odd",     16'h3C01, 16'h1000, 16'h0000, 16'h0000, 4'b0000, 16'h3C02, 5'b00010, 0);
    run_group("tie even",    16'h3C00, 16'h1000, 16'h0000, 16'h0000, 4'b0000, 16'h3C00, 5'b00010, 0);
    run_group("overflow",    16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h7BFF, 4'b0000, 16'h7C00, 5'b01010, 0);
    run_group("inf-inf",     16'h7C00, 16'hFC00, 16'h0000, 16'h0000, 4'b0000, 16'h7E00, 5'b10000, 0);
    run_group("sticky exc",  16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'b0010, 16'h4400, 5'b00001, 0);
    run_group("hold",        16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 16'h4400, 5'b00000, 10);
    run_group("after hold",  16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 16'h4400, 5'b00000, 0);

    send_product(16'h3C00, 1'b0);
    send_product(16'h3C00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midgroup reset in_ready", 32'(in_ready), 32'd1);
    check_eq("midgroup reset out_valid", 32'(out_valid), 32'd0);
    check_eq("midgroup reset out_data", 32'(out_data), 32'd0);
    check_eq("midgroup reset out_flags", 32'(out_flags), 32'd0);
    check_eq("midgroup reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    run_group("twos",        16'h4000, 16'h4000, 16'h4000, 16'h4000, 4'b0000, 16'h4800, 5'b00000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
